// File: rtl/lfsr_crypt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_crypt_pkg
//  Brief    : Shared types, tap table and LFSR step for the cipher sequencer.
//  Revision : 1.0
// ============================================================================
package lfsr_crypt_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LD_PRE  = 4'd1,
        LD_TAP  = 4'd2,
        LD_SEED = 4'd3,
        ENC     = 4'd4,
        D_SEED  = 4'd5,
        D_TRY   = 4'd6,
        D_COPY  = 4'd7,
        D_FILL  = 4'd8,
        DONE    = 4'd9
    } state_t;

    localparam logic [7:0] SPACE = 8'h20;

    localparam logic [7:0] TAP_TABLE [8] = '{
        8'hE1, 8'hD4, 8'hC6, 8'hB8, 8'hB4, 8'hB2, 8'hFA, 8'hF3
    };

    function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] taps);
        return {s[6:0], ^(s & taps)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_crypt_seq_lfsr8.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr8
//  Brief    : 8-bit Fibonacci LFSR with synchronous load and step.
//  Revision : 1.0
// ============================================================================
module lfsr8
    import lfsr_crypt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_step,
    input  logic [7:0] i_taps,
    output logic [7:0] o_state
);

    logic [7:0] r_state;

    // Load has priority so a reseed and a step never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= i_load_val;
        end else if (i_step) begin
            r_state <= lfsr_next(r_state, i_taps);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/lfsr_crypt_seq.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_crypt_seq
//  Brief    : Encrypt/decrypt sequencer owning the data-memory port during a run.
//  Revision : 1.0
// ============================================================================
module lfsr_crypt_seq
    import lfsr_crypt_pkg::*;
#(
    parameter int unsigned MSG_LEN   = 41,
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned CT_BASE   = 64,
    parameter int unsigned PARM_BASE = 41
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mode,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] c_msg_len   = 8'(MSG_LEN);
    localparam logic [7:0] c_last_idx  = 8'(FRAME_LEN - 1);
    localparam logic [7:0] c_ct_base   = 8'(CT_BASE);
    localparam logic [7:0] c_parm_base = 8'(PARM_BASE);
    localparam logic [7:0] c_try_last  = 8'd8;

    state_t     r_state;
    logic       r_mode, r_phase, r_seen, r_err;
    logic [7:0] r_pre, r_taps, r_seed, r_idx, r_n, r_wdata;
    logic [2:0] r_t;

    logic       w_load, w_step, w_k_valid, w_try_ok;
    logic [7:0] w_load_val, w_taps, w_s, w_s_next, w_k, w_plain, w_dec;

    lfsr8 u_lfsr (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_step     (w_step),
        .i_taps     (w_taps),
        .o_state    (w_s)
    );

    assign w_taps    = r_mode ? TAP_TABLE[r_t] : r_taps;
    assign w_s_next  = lfsr_next(w_s, w_taps);
    // Plaintext index is valid only once i has passed the preamble, so no wrap.
    assign w_k       = r_idx - r_pre;
    assign w_k_valid = (r_idx >= r_pre) && (w_k < c_msg_len);
    assign w_plain   = w_k_valid ? mem_rd_data : SPACE;
    assign w_dec     = mem_rd_data ^ w_s;
    assign w_try_ok  = ((mem_rd_data ^ w_s_next) == SPACE);

    assign busy = (r_state != IDLE) && (r_state != DONE);
    assign done = (r_state == DONE);
    assign err  = r_err;

    always_comb begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = r_wdata;
        w_load      = 1'b0;
        w_load_val  = mem_rd_data;
        w_step      = 1'b0;
        case (r_state)
            LD_PRE:  mem_addr = c_parm_base;
            LD_TAP:  mem_addr = c_parm_base + 8'd1;
            LD_SEED: begin
                mem_addr = c_parm_base + 8'd2;
                w_load   = 1'b1;
            end
            ENC: begin
                if (!r_phase) begin
                    mem_addr = w_k_valid ? w_k : 8'd0;
                end else begin
                    mem_addr  = c_ct_base + r_idx;
                    mem_wr_en = 1'b1;
                    w_step    = 1'b1;
                end
            end
            D_SEED: begin
                mem_addr   = c_ct_base;
                w_load     = 1'b1;
                w_load_val = mem_rd_data ^ SPACE;
            end
            D_TRY: begin
                mem_addr = c_ct_base + r_idx;
                // Any exit from a trial (fail or success) rewinds to the seed.
                if (w_try_ok && (r_idx != c_try_last)) begin
                    w_step = 1'b1;
                end else begin
                    w_load     = 1'b1;
                    w_load_val = r_seed;
                end
            end
            D_COPY: begin
                if (!r_phase) begin
                    mem_addr = c_ct_base + r_idx;
                    w_step   = !r_seen && (w_dec == SPACE);
                end else begin
                    mem_addr  = r_n;
                    mem_wr_en = 1'b1;
                    w_step    = 1'b1;
                end
            end
            D_FILL: begin
                mem_addr    = r_n;
                mem_wr_en   = (r_n < c_msg_len);
                mem_wr_data = SPACE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_mode  <= 1'b0;
            r_phase <= 1'b0;
            r_seen  <= 1'b0;
            r_err   <= 1'b0;
            r_pre   <= '0;
            r_taps  <= '0;
            r_seed  <= '0;
            r_idx   <= '0;
            r_n     <= '0;
            r_wdata <= '0;
            r_t     <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_err   <= 1'b0;
                        r_mode  <= mode;
                        r_phase <= 1'b0;
                        r_idx   <= '0;
                        r_state <= mode ? D_SEED : LD_PRE;
                    end
                end
                LD_PRE: begin
                    r_pre   <= mem_rd_data;
                    r_state <= LD_TAP;
                end
                LD_TAP: begin
                    r_taps  <= mem_rd_data;
                    r_state <= LD_SEED;
                end
                LD_SEED: r_state <= ENC;
                ENC: begin
                    if (!r_phase) begin
                        r_wdata <= w_plain ^ w_s;
                        r_phase <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        if (r_idx == c_last_idx) r_state <= DONE;
                        else                     r_idx   <= r_idx + 8'd1;
                    end
                end
                D_SEED: begin
                    r_seed  <= mem_rd_data ^ SPACE;
                    r_t     <= '0;
                    r_idx   <= 8'd1;
                    r_state <= D_TRY;
                end
                D_TRY: begin
                    if (!w_try_ok) begin
                        if (r_t == 3'd7) begin
                            r_err   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_t   <= r_t + 3'd1;
                            r_idx <= 8'd1;
                        end
                    end else if (r_idx == c_try_last) begin
                        r_idx   <= '0;
                        r_n     <= '0;
                        r_seen  <= 1'b0;
                        r_phase <= 1'b0;
                        r_state <= D_COPY;
                    end else begin
                        r_idx <= r_idx + 8'd1;
                    end
                end
                D_COPY: begin
                    if (!r_phase) begin
                        r_wdata <= w_dec;
                        if (r_seen || (w_dec != SPACE)) begin
                            r_seen  <= 1'b1;
                            r_phase <= 1'b1;
                        end else if (r_idx == c_last_idx) begin
                            r_state <= D_FILL;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end else begin
                        r_phase <= 1'b0;
                        r_n     <= r_n + 8'd1;
                        if ((r_n + 8'd1) == c_msg_len) r_state <= DONE;
                        else if (r_idx == c_last_idx)  r_state <= D_FILL;
                        else                           r_idx   <= r_idx + 8'd1;
                    end
                end
                D_FILL: begin
                    if (r_n < c_msg_len) r_n <= r_n + 8'd1;
                    if ((r_n + 8'd1) >= c_msg_len) r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
